demux4_32bits_buf: RTL
======================

Name: demux4_32bits_buf

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake; the routing counterpart of the 4:1 32-bit select mux in the datapath.
- Takes one 32-bit word plus a 2-bit destination select and delivers it into one of four single-entry output buffers.
- Each output has its own valid/ready handshake, so a stalled consumer blocks only the traffic addressed to it.
- Per-channel delivery counters are kept for debug and performance monitoring.

Parameters:
- WIDTH, 32, data width of the input and of each output.
- CNT_W, 16, width of each per-channel delivery counter.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  the channel addressed by choice can accept the word this cycle.
- choice  input  2  destination channel, 0..3; sampled only with in_valid.
- in_data  input  WIDTH  word to route.
- out_valid  output  4  bit k high when buffer k holds a word.
- out_ready  input  4  bit k high when consumer k takes the word this cycle.
- out0, out1, out2, out3  output  WIDTH each  contents of buffers 0..3.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  number of words popped from each channel.
- busy  output  1  OR of all out_valid bits.

Behaviour:
- Reset (rst_n low, async):
  - out_valid = 4'b0000.
  - out0..out3 = 0.
  - cnt0..cnt3 = 0.
  - busy = 0.
  - Any word held in a buffer is discarded.
  - A push or pop in flight when reset asserts is lost.
  - State stays at reset values while rst_n is low; normal operation resumes on the first rising edge after rst_n goes high.
- in_ready is combinational: in_ready = !out_valid[choice] | out_ready[choice]. It depends only on the addressed channel.
- Push:
  - Condition: in_valid & in_ready.
  - At the next edge, buffer[choice] <= in_data and out_valid[choice] <= 1.
  - Latency from input to output is 1 cycle.
  - No combinational path from in_data to any outN.
- Pop:
  - Condition: out_valid[k] & out_ready[k].
  - At the next edge, out_valid[k] <= 0 (unless a push to k happens in the same cycle) and cnt_k increments by 1.
  - out_ready[k] while out_valid[k] is 0 has no effect.
- Simultaneous push and pop on the same channel k:
  - Buffer k loads the new word.
  - out_valid[k] stays 1.
  - cnt_k increments.
  - This gives full throughput of 1 word per cycle per channel.
- Push to channel j while other channels pop: independent; all take effect at the same edge.
- Full channel with out_ready low:
  - in_ready = 0 while choice points to it.
  - The producer must hold in_valid, choice and in_data stable until in_ready = 1.
  - Changing choice to a free channel raises in_ready in the same cycle.
- outN holds its last value after a pop; it is not cleared. Consumers qualify outN with out_valid[N].
- Counters are modulo 2^CNT_W: 0xFFFF + 1 wraps to 0x0000 with no flag.
- busy is registered-equivalent: it is derived only from the out_valid flops.
- in_valid low: no state change; choice and in_data are don't-care.
- No X-propagation is allowed from choice when in_valid is low; all outputs are defined from reset onward.

Test Plan:
- Reset check: drive rst_n=0 mid-run with buffers 1 and 3 full -> immediately out_valid=0000, out0..3=0, cnt0..3=0, busy=0.
- Basic routing: choice=2, in_data=0xDEADBEEF, in_valid=1 for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, out2=0xDEADBEEF; raise out_ready[2] -> following cycle out_valid=0000, cnt2=1, out2 still 0xDEADBEEF.
- Back-pressure: fill channel 1 with 0x11111111, then present 0x22222222 to choice=1 with out_ready[1]=0 -> in_ready=0 and out1 remains 0x11111111; switch choice to 0 -> in_ready=1 the same cycle and 0x22222222 lands in out0.
- Streaming: out_ready=1111, push 0x0..0x7 to channel 3 on consecutive cycles -> in_ready stays 1, out3 shows 0x0..0x7 one cycle delayed, cnt3=8 at the end.
- Parallel channels: push to channels 0, 1, 2, 3 on four cycles with out_ready=0000 -> out_valid=1111 and busy=1; then out_ready=1010 -> next cycle out_valid=0101, cnt1=1, cnt3=1, cnt0=cnt2=0.
- Counter wrap: preload by streaming 65535 pops on channel 0, then one more pop -> cnt0 goes 0xFFFF then 0x0000, other counters unchanged.

Source files
------------

// File: rtl/demux4_32bits_buf.sv
// Registered 1-to-4 demultiplexer. Each destination has a single-entry buffer
// with its own valid/ready handshake and a popped-word counter.

module demux4_32bits_buf_lane #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  assign pop = vld_q & rdy;

  // A same-cycle pop and push leaves the entry full with the new word.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d = 1'b0;
      cnt_d = cnt_q + 1'b1;
    end
    if (push) begin
      vld_d  = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign vld  = vld_q;
  assign dout = data_q;
  assign cnt  = cnt_q;
endmodule

module demux4_32bits_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       choice,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic             busy
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            push, vld;
  logic [NUM_LANES-1:0][WIDTH-1:0] dout;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

  // Readiness looks only at the addressed lane, so a stalled lane blocks nobody else.
  assign in_ready = !vld[choice] | out_ready[choice];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign push[g] = in_valid & in_ready & (choice == 2'(g));
    demux4_32bits_buf_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[g]),
      .din  (in_data),
      .rdy  (out_ready[g]),
      .vld  (vld[g]),
      .dout (dout[g]),
      .cnt  (cnt[g])
    );
  end

  assign out_valid = vld;
  assign busy      = |vld;
  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
endmodule
